// File: rtl/shifter_pkg.sv
// Shared types and direction constants for the pipelined barrel shifter.
// Mode 2'b11 is reserved and decodes as a logical shift.
package shifter_pkg;

  typedef enum logic [1:0] {
    LOGICAL = 2'b00,
    ARITH   = 2'b01,
    ROTATE  = 2'b10,
    RSVD    = 2'b11
  } shift_mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by 2**K, then an enabled pipeline register.
// Rotate support is compiled in only when SHIFTER_ROTATE_EN is defined; otherwise rotate decodes as logical.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 vld_i,
  input  logic [W-1:0]         dat_i,
  input  logic [$clog2(W)-1:0] amt_i,
  input  logic                 dir_i,
  input  shift_mode_t          mode_i,
  output logic                 vld_o,
  output logic [W-1:0]         dat_o,
  output logic [$clog2(W)-1:0] amt_o,
  output logic                 dir_o,
  output shift_mode_t          mode_o
);

  localparam int S = 2 ** K;

  logic [W-1:0]         dat_d;
  logic                 vld_q;
  logic [W-1:0]         dat_q;
  logic [$clog2(W)-1:0] amt_q;
  logic                 dir_q;
  shift_mode_t          mode_q;

  // Arithmetic right stays correct across stages because each stage preserves the sign bit.
  always_comb begin
    dat_d = dat_i;
    if (amt_i[K]) begin
      case (dir_i)
        DIR_LEFT:  dat_d = dat_i << S;
        DIR_RIGHT: begin
          if (mode_i == ARITH) dat_d = $signed(dat_i) >>> S;
          else                 dat_d = dat_i >> S;
        end
      endcase
`ifdef SHIFTER_ROTATE_EN
      if (mode_i == ROTATE) begin
        if (dir_i == DIR_LEFT) dat_d = (dat_i << S) | (dat_i >> (W - S));
        else                   dat_d = (dat_i >> S) | (dat_i << (W - S));
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      amt_q  <= '0;
      dir_q  <= DIR_RIGHT;
      mode_q <= LOGICAL;
    end else if (en_i) begin
      vld_q  <= vld_i;
      dat_q  <= dat_d;
      amt_q  <= amt_i;
      dir_q  <= dir_i;
      mode_q <= mode_i;
    end
  end

  assign vld_o  = vld_q;
  assign dat_o  = dat_q;
  assign amt_o  = amt_q;
  assign dir_o  = dir_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-stage pipelined barrel shifter with valid/ready handshake; one result per cycle, latency N.
// A single global enable freezes every stage when the output is held; rotate gated by SHIFTER_ROTATE_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [N-1:0] amt,
  input  logic         dir,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
);

  logic         en;
  logic         vld_s  [N+1];
  logic [W-1:0] dat_s  [N+1];
  logic [N-1:0] amt_s  [N+1];
  logic         dir_s  [N+1];
  shift_mode_t  mode_s [N+1];

  // Bubbles advance with the pipe, so the enable only needs to look at the last stage.
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  assign vld_s[0]  = in_valid;
  assign dat_s[0]  = a;
  assign amt_s[0]  = amt;
  assign dir_s[0]  = dir;
  assign mode_s[0] = shift_mode_t'(mode);

  for (genvar k = 0; k < N; k++) begin : g_stage
    shift_stage #(
      .W (W),
      .K (k)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .vld_i  (vld_s[k]),
      .dat_i  (dat_s[k]),
      .amt_i  (amt_s[k]),
      .dir_i  (dir_s[k]),
      .mode_i (mode_s[k]),
      .vld_o  (vld_s[k+1]),
      .dat_o  (dat_s[k+1]),
      .amt_o  (amt_s[k+1]),
      .dir_o  (dir_s[k+1]),
      .mode_o (mode_s[k+1])
    );
  end

  assign out_valid = vld_s[N];
  assign y         = dat_s[N];

endmodule
